// File: rtl/mod_counter.sv
// Up/down modulo counter over 0..max_val with a per-cycle step size.
// An out-of-range result either wraps or clamps, and raises a terminal-count pulse and a sticky flag.
module mod_counter #(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ld,
  input  logic             dir,
  input  logic [WIDTH-1:0] ld_val,
  input  logic [WIDTH-1:0] max_val,
  input  logic [WIDTH-1:0] step,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf_sticky
);

  localparam logic CLAMP = (SATURATE != 0);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] nxt_count;
  logic             range_evt;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    nxt_count = count;
    range_evt = 1'b0;
    sum       = {1'b0, count} + {1'b0, step};

    if (ld) begin
      nxt_count = (ld_val > max_val) ? max_val : ld_val;
    end else if (en && (step != '0)) begin
      if (count > max_val) begin
        // max_val was lowered below the current count.
        range_evt = 1'b1;
      end else if (dir) begin
        if (sum <= {1'b0, max_val}) nxt_count = sum[WIDTH-1:0];
        else                        range_evt = 1'b1;
      end else begin
        if (count >= step) nxt_count = count - step;
        else               range_evt = 1'b1;
      end

      // Up+clamp and down+wrap land on max_val; the other two cases land on 0.
      if (range_evt) nxt_count = (dir == CLAMP) ? max_val : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (!rst) begin
      count      <= '0;
      tc         <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      count <= nxt_count;
      tc    <= range_evt;
      if (range_evt)    ovf_sticky <= 1'b1;
      else if (clr_ovf) ovf_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter: a wrap instance and a clamp instance share the same stimulus,
// and both are checked against directed sequences and an arithmetic reference model.
module tb_mod_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, ld = 1'b0, dir = 1'b0, clr_ovf = 1'b0;
  logic [7:0] ld_val = '0, max_val = '0, step = '0;
  logic [7:0] cnt_w, cnt_c;
  logic       tc_w, tc_c, ovf_w, ovf_c;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state, index 0 = wrap, 1 = clamp.
  int m_count[2];
  bit m_tc[2];
  bit m_ovf[2];

  always #5 clk = ~clk;

  mod_counter #(.WIDTH(8), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .ld(ld), .dir(dir), .ld_val(ld_val),
    .max_val(max_val), .step(step), .clr_ovf(clr_ovf),
    .count(cnt_w), .tc(tc_w), .ovf_sticky(ovf_w)
  );

  mod_counter #(.WIDTH(8), .SATURATE(1)) u_clamp (
    .clk(clk), .rst(rst), .en(en), .ld(ld), .dir(dir), .ld_val(ld_val),
    .max_val(max_val), .step(step), .clr_ovf(clr_ovf),
    .count(cnt_c), .tc(tc_c), .ovf_sticky(ovf_c)
  );

  // Behavioural model: the count is an integer that must stay inside 0..max_val.
  task automatic model_edge();
    for (int s = 0; s < 2; s++) begin
      int  mx;
      int  target;
      bit  ev;
      mx = int'(max_val);
      ev = 1'b0;
      if (ld) begin
        m_count[s] = (int'(ld_val) > mx) ? mx : int'(ld_val);
      end else if (en && step != 0) begin
        target = dir ? m_count[s] + int'(step) : m_count[s] - int'(step);
        ev = (m_count[s] > mx) || (target < 0) || (target > mx);
        if (!ev)     m_count[s] = target;
        else if (dir) m_count[s] = (s == 1) ? mx : 0;
        else          m_count[s] = (s == 1) ? 0 : mx;
      end
      m_tc[s] = ev;
      if (ev)           m_ovf[s] = 1'b1;
      else if (clr_ovf) m_ovf[s] = 1'b0;
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_count[s] = 0;
      m_tc[s]    = 1'b0;
      m_ovf[s]   = 1'b0;
    end
  endtask

  // One active edge; outputs are stable 1 time unit later.
  task automatic tick();
    @(posedge clk);
    if (rst) model_edge();
    else     model_reset();
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    en = 1'b1; dir = 1'b1; step = 8'd1; max_val = 8'd9;
    repeat (3) tick();
    n_cmp++;
    if ({cnt_w, tc_w, ovf_w} !== 10'd0) begin
      n_err++;
      $display("FAIL reset_wrap: got count=%0d tc=%0b ovf=%0b, need 0/0/0", cnt_w, tc_w, ovf_w);
    end
    n_cmp++;
    if ({cnt_c, tc_c, ovf_c} !== 10'd0) begin
      n_err++;
      $display("FAIL reset_clamp: got count=%0d tc=%0b ovf=%0b, need 0/0/0", cnt_c, tc_c, ovf_c);
    end
    #2 rst = 1'b1;
  endtask

  // Count 0..9 then wrap to 0 with a single tc pulse.
  task automatic test_wrap_up();
    for (int i = 1; i <= 10; i++) begin
      int exp_c;
      bit exp_t;
      tick();
      exp_c = (i == 10) ? 0 : i;
      exp_t = (i == 10);
      n_cmp++;
      if (cnt_w !== 8'(exp_c) || tc_w !== exp_t) begin
        n_err++;
        $display("FAIL wrap_up step %0d: got count=%0d tc=%0b, need count=%0d tc=%0b",
                 i, cnt_w, tc_w, exp_c, exp_t);
      end
    end
    n_cmp++;
    if (ovf_w !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_up ovf: got %0b, need 1", ovf_w);
    end
  endtask

  // Load 4 then count down by 3 through two wraps to max_val.
  task automatic test_wrap_down();
    int exp_c[7] = '{4, 1, 9, 6, 3, 0, 9};
    bit exp_t[7] = '{0, 0, 1, 0, 0, 0, 1};
    ld = 1'b1; ld_val = 8'd4; dir = 1'b0; step = 8'd3; max_val = 8'd9;
    for (int i = 0; i < 7; i++) begin
      tick();
      ld = 1'b0;
      n_cmp++;
      if (cnt_w !== 8'(exp_c[i]) || tc_w !== exp_t[i]) begin
        n_err++;
        $display("FAIL wrap_down step %0d: got count=%0d tc=%0b, need count=%0d tc=%0b",
                 i, cnt_w, tc_w, exp_c[i], exp_t[i]);
      end
    end
  endtask

  // Step 100 against limit 200: the 9-bit sum must not wrap past 255.
  task automatic test_clamp();
    int exp_cc[4] = '{100, 200, 200, 200};
    int exp_cw[4] = '{100, 200, 0, 100};
    bit exp_t[4]  = '{0, 0, 1, 1};
    ld = 1'b1; ld_val = 8'd0; en = 1'b1;
    tick();
    ld = 1'b0; max_val = 8'd200; step = 8'd100; dir = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (cnt_c !== 8'(exp_cc[i]) || tc_c !== exp_t[i]) begin
        n_err++;
        $display("FAIL clamp_up step %0d: got count=%0d tc=%0b, need count=%0d tc=%0b",
                 i, cnt_c, tc_c, exp_cc[i], exp_t[i]);
      end
      n_cmp++;
      if (cnt_w !== 8'(exp_cw[i]) || tc_w !== (i == 2)) begin
        n_err++;
        $display("FAIL wrap_up_big step %0d: got count=%0d tc=%0b, need count=%0d tc=%0b",
                 i, cnt_w, tc_w, exp_cw[i], (i == 2));
      end
    end
  endtask

  // Load value above the limit clips; then the limit drops below the count.
  task automatic test_load_clip();
    ld = 1'b1; en = 1'b1; ld_val = 8'd250; max_val = 8'd100;
    tick();
    n_cmp++;
    if (cnt_w !== 8'd100 || tc_w !== 1'b0 || cnt_c !== 8'd100 || tc_c !== 1'b0) begin
      n_err++;
      $display("FAIL load_clip: got w=%0d/%0b c=%0d/%0b, need 100/0 both", cnt_w, tc_w, cnt_c, tc_c);
    end
    ld = 1'b0; max_val = 8'd50; dir = 1'b0; step = 8'd1;
    tick();
    n_cmp++;
    if (cnt_w !== 8'd50 || tc_w !== 1'b1) begin
      n_err++;
      $display("FAIL out_of_range_wrap: got count=%0d tc=%0b, need 50/1", cnt_w, tc_w);
    end
    n_cmp++;
    if (cnt_c !== 8'd0 || tc_c !== 1'b1) begin
      n_err++;
      $display("FAIL out_of_range_clamp: got count=%0d tc=%0b, need 0/1", cnt_c, tc_c);
    end
  endtask

  task automatic test_sticky_and_async_reset();
    en = 1'b0; clr_ovf = 1'b1;
    tick();
    n_cmp++;
    if (ovf_w !== 1'b0 || tc_w !== 1'b0) begin
      n_err++;
      $display("FAIL clr_ovf: got ovf=%0b tc=%0b, need 0/0", ovf_w, tc_w);
    end
    // Range event (max_val=0, step!=0) with clr_ovf held high: set wins.
    max_val = 8'd0; en = 1'b1; dir = 1'b1; step = 8'd5;
    tick();
    n_cmp++;
    if (ovf_w !== 1'b1 || tc_w !== 1'b1 || cnt_w !== 8'd0) begin
      n_err++;
      $display("FAIL set_beats_clr: got ovf=%0b tc=%0b count=%0d, need 1/1/0", ovf_w, tc_w, cnt_w);
    end
    en = 1'b0;
    tick();
    n_cmp++;
    if (ovf_w !== 1'b0 || tc_w !== 1'b0) begin
      n_err++;
      $display("FAIL clr_after_set: got ovf=%0b tc=%0b, need 0/0", ovf_w, tc_w);
    end
    clr_ovf = 1'b0; ld = 1'b1; ld_val = 8'd7; max_val = 8'd9;
    tick();
    ld = 1'b0; en = 1'b1; dir = 1'b1; step = 8'd9;
    n_cmp++;
    if (cnt_w !== 8'd7) begin
      n_err++;
      $display("FAIL load_7: got count=%0d, need 7", cnt_w);
    end
    // A range event is pending (7+9 > 9); assert reset between edges.
    #2 rst = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (cnt_w !== 8'd0 || tc_w !== 1'b0 || ovf_w !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: got count=%0d tc=%0b ovf=%0b, need 0/0/0", cnt_w, tc_w, ovf_w);
    end
    en = 1'b0;
    #1 rst = 1'b1;
    tick();
    n_cmp++;
    if (cnt_w !== 8'd0 || tc_w !== 1'b0 || cnt_c !== 8'd0 || tc_c !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: got w=%0d/%0b c=%0d/%0b, need 0/0 both", cnt_w, tc_w, cnt_c, tc_c);
    end
  endtask

  task automatic test_random();
    max_val = 8'd20;
    for (int i = 0; i < 400; i++) begin
      ld      = ($urandom_range(0, 7) == 0);
      en      = ($urandom_range(0, 3) != 0);
      dir     = $urandom_range(0, 1);
      clr_ovf = ($urandom_range(0, 7) == 0);
      ld_val  = 8'($urandom_range(0, 255));
      step    = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
      if ($urandom_range(0, 15) == 0)
        max_val = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      if ($urandom_range(0, 31) == 0) step = 8'($urandom_range(100, 255));
      tick();
      n_cmp++;
      if (cnt_w !== 8'(m_count[0]) || tc_w !== m_tc[0] || ovf_w !== m_ovf[0]) begin
        n_err++;
        $display("FAIL random_wrap cycle %0d: got %0d/%0b/%0b, need %0d/%0b/%0b",
                 i, cnt_w, tc_w, ovf_w, m_count[0], m_tc[0], m_ovf[0]);
      end
      n_cmp++;
      if (cnt_c !== 8'(m_count[1]) || tc_c !== m_tc[1] || ovf_c !== m_ovf[1]) begin
        n_err++;
        $display("FAIL random_clamp cycle %0d: got %0d/%0b/%0b, need %0d/%0b/%0b",
                 i, cnt_c, tc_c, ovf_c, m_count[1], m_tc[1], m_ovf[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_clamp();
    test_load_clip();
    test_sticky_and_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 Parameter WIDTH, default 8, counter and data width in bits (>= 2).
REQ-002 Parameter SATURATE, default 0. 0 selects wrap mode; 1 selects clamp-at-limit mode.
REQ-003 clk  input  1  Clock; all state changes on the rising edge.
REQ-004 rst  input  1  Reset; asynchronous, active-low (0 = reset asserted).
REQ-005 en  input  1  Count enable.
REQ-006 ld  input  1  Synchronous load; takes priority over en.
REQ-007 dir  input  1  Direction: 1 = up, 0 = down.
REQ-008 ld_val  input  WIDTH  Load value.
REQ-009 max_val  input  WIDTH  Upper bound of the count range; the range is 0..max_val inclusive.
REQ-010 step  input  WIDTH  Increment/decrement magnitude per enabled cycle.
REQ-011 clr_ovf  input  1  Clears ovf_sticky.
REQ-012 count  output  WIDTH  Registered count value.
REQ-013 tc  output  WIDTH=1  Registered terminal-count pulse, 1 bit.
REQ-014 ovf_sticky  output  1  Registered sticky flag; set on any range event.

Function
REQ-015 Priority each cycle SHALL be: rst > ld > en > hold.
REQ-016 ld=1: count SHALL take ld_val if ld_val <= max_val, else max_val; no range event; tc=0 next cycle.
REQ-017 ld=0, en=0: count SHALL hold; tc=0 next cycle.
REQ-018 en=1, step=0: count SHALL hold; no range event.
REQ-019 en=1, dir=1: sum = count + step, computed in WIDTH+1 bits (no truncation).
- sum <= max_val: count <= sum.
- Otherwise: this is a range event.
REQ-020 en=1, dir=0: if count >= step, count <= count - step; otherwise this is a range event.
REQ-021 Range event, SATURATE=0 (wrap):
- Up: count SHALL become 0.
- Down: count SHALL become max_val.
REQ-022 Range event, SATURATE=1 (clamp):
- Up: count SHALL become max_val.
- Down: count SHALL become 0.
- The event is still flagged when count is already at the limit.
REQ-023 Out-of-range state: if en=1, ld=0 and count > max_val (max_val lowered mid-operation), this SHALL be a range event regardless of dir. Resulting count per REQ-021/022 for the current dir.
REQ-024 tc SHALL be 1 for exactly the cycle following each range event, else 0. Consecutive events give consecutive tc=1 cycles.
REQ-025 ovf_sticky SHALL set on a range event and clear when clr_ovf=1. If both occur in the same cycle, set wins.
REQ-026 max_val=0: count SHALL remain 0. Every enabled cycle with step != 0 is a range event.
REQ-027 Latency: count, tc and ovf_sticky SHALL all reflect inputs sampled at edge N at edge N (one-cycle registered); no combinational input-to-output paths.

Reset
REQ-028 While rst=0, count=0, tc=0 and ovf_sticky=0 SHALL hold immediately, independent of clk.
REQ-029 The first active edge after rst rises SHALL obey REQ-015..REQ-026 from count=0.
REQ-030 Reset asserted mid-count SHALL discard any pending event; no tc pulse follows release.

Verification
REQ-031 WIDTH=8, SATURATE=0, max_val=9, step=1, dir=1, en=1 from reset -> count 0..9, then 0; tc=1 only in the cycle count shows 0 after 9; ovf_sticky=1.
REQ-032 SATURATE=0, max_val=9, step=3, dir=0, ld_val=4 loaded -> count 4, 1, 9 (tc=1), 6, 3, 0, 9 (tc=1).
REQ-033 SATURATE=1, max_val=200, step=100, dir=1 from 0 -> 100, 200, 200 (tc=1), 200 (tc=1); WIDTH+1 sum prevents wrap at 255.
REQ-034 ld=1, en=1, ld_val=250, max_val=100 -> count=100, tc=0. Next cycle max_val=50, en=1, dir=0 -> range event: count=50 (wrap mode), tc=1.
REQ-035 Range event and clr_ovf=1 in the same cycle -> ovf_sticky stays 1. clr_ovf alone -> 0. rst=0 asserted between edges at count=7 -> count=0 immediately, tc=0.
